rv32i_pc_alu_datapath: RTL and testbench

RV32I_PC_ALU_DATAPATH -- requirements
Module: rv32i_pc_alu_datapath

---
 rtl/rv32i_pc_alu_datapath_if.sv | 32 +++
 rtl/rv32i_pc_alu_datapath.sv | 110 +++++++++++
 tb/tb_rv32i_pc_alu_datapath.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pc_alu_datapath_if.sv
// Signal bundle between the RV32I control/decode logic and the PC/ALU datapath.
// The datapath connects through the slave modport; the decode side uses master.
interface rv32i_pc_alu_datapath_if;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm_i;
  logic [31:0] imm_sb;
  logic [31:0] imm_uj;
  logic        branch_en;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [11:0] imem_addr;
  logic [31:0] alu_result;
  logic        branch_taken;

  modport master (
    output pc_en, pc_sel, alu_op, op_a, op_b, imm_i, imm_sb, imm_uj,
           branch_en, funct3,
    input  pc, pc_plus4, pc_next, imem_addr, alu_result, branch_taken
  );

  modport slave (
    input  pc_en, pc_sel, alu_op, op_a, op_b, imm_i, imm_sb, imm_uj,
           branch_en, funct3,
    output pc, pc_plus4, pc_next, imem_addr, alu_result, branch_taken
  );
endinterface

// File: rtl/rv32i_pc_alu_datapath.sv
// RV32I program counter, next-PC selection, branch compare and ALU.
// Only the PC is registered; every other output is combinational from pc and inputs.
module rv32i_pc_alu_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  rv32i_pc_alu_datapath_if.slave dp
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_JAL    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_JALR   = 2'd3;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_target;
  logic [31:0] pc_next;
  logic [31:0] alu_result;
  logic [4:0]  shamt;
  logic        cond_met;
  logic        branch_taken;

  // All address sums are plain 32-bit adds; wrap is intentional and no
  // misalignment check is made.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_q + dp.imm_sb;
  assign jal_target    = pc_q + dp.imm_uj;
  assign jalr_sum      = dp.op_a + dp.imm_i;
  assign jalr_target   = {jalr_sum[31:1], 1'b0};

  always_comb begin
    cond_met = 1'b0;
    case (dp.funct3)
      3'b000:  cond_met = (dp.op_a == dp.op_b);
      3'b001:  cond_met = (dp.op_a != dp.op_b);
      3'b100:  cond_met = ($signed(dp.op_a) <  $signed(dp.op_b));
      3'b101:  cond_met = ($signed(dp.op_a) >= $signed(dp.op_b));
      3'b110:  cond_met = (dp.op_a <  dp.op_b);
      3'b111:  cond_met = (dp.op_a >= dp.op_b);
      default: cond_met = 1'b0;
    endcase
  end

  assign branch_taken = dp.branch_en & cond_met;

  always_comb begin
    pc_next = pc_plus4;
    case (dp.pc_sel)
      SEL_SEQ:    pc_next = pc_plus4;
      SEL_JAL:    pc_next = jal_target;
      SEL_BRANCH: pc_next = branch_taken ? branch_target : pc_plus4;
      SEL_JALR:   pc_next = jalr_target;
      default:    pc_next = pc_plus4;
    endcase
  end

  assign shamt = dp.op_b[4:0];

  always_comb begin
    alu_result = 32'h0;
    case (dp.alu_op)
      ALU_ADD:    alu_result = dp.op_a + dp.op_b;
      ALU_SUB:    alu_result = dp.op_a - dp.op_b;
      ALU_SLL:    alu_result = dp.op_a << shamt;
      ALU_SLT:    alu_result = {31'd0, $signed(dp.op_a) < $signed(dp.op_b)};
      ALU_SLTU:   alu_result = {31'd0, dp.op_a < dp.op_b};
      ALU_XOR:    alu_result = dp.op_a ^ dp.op_b;
      ALU_SRL:    alu_result = dp.op_a >> shamt;
      ALU_SRA:    alu_result = $unsigned($signed(dp.op_a) >>> shamt);
      ALU_OR:     alu_result = dp.op_a | dp.op_b;
      ALU_AND:    alu_result = dp.op_a & dp.op_b;
      ALU_PASS_B: alu_result = dp.op_b;
      default:    alu_result = 32'h0;
    endcase
  end

  // Reset wins over pc_en so a mid-stream reset drops whatever pc_next was pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (dp.pc_en) begin
      pc_q <= pc_next;
    end
  end

  assign dp.pc           = pc_q;
  assign dp.pc_plus4     = pc_plus4;
  assign dp.pc_next      = pc_next;
  assign dp.imem_addr    = pc_q[13:2];
  assign dp.alu_result   = alu_result;
  assign dp.branch_taken = branch_taken;

endmodule

// File: tb/tb_rv32i_pc_alu_datapath.sv
// Directed bench for rv32i_pc_alu_datapath: stimulus pushes expected values,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_rv32i_pc_alu_datapath;

  typedef enum int {K_PC, K_PLUS4, K_NEXT, K_IMEM, K_ALU, K_TAKEN} kind_t;

  typedef struct {
    kind_t       kind;
    string       name;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       name;
  } alu_vec_t;

  typedef struct {
    logic        en;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic [31:0] next;
    string       name;
  } br_vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rv32i_pc_alu_datapath_if dp_if ();

  rv32i_pc_alu_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dut_val(kind_t k);
    case (k)
      K_PC:    return dp_if.pc;
      K_PLUS4: return dp_if.pc_plus4;
      K_NEXT:  return dp_if.pc_next;
      K_IMEM:  return {20'd0, dp_if.imem_addr};
      K_ALU:   return dp_if.alu_result;
      default: return {31'd0, dp_if.branch_taken};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e   = sb.pop_front();
      got = dut_val(e.kind);
      checks++;
      if (got !== e.value) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.value);
      end
    end
  end

  task automatic expect_val(kind_t k, string name, logic [31:0] v);
    exp_t e;
    e.kind  = k;
    e.name  = name;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  alu_vec_t alu_tab[14] = '{
    '{4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE, "alu_sub"},
    '{4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, "alu_sra"},
    '{4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000, "alu_srl"},
    '{4'd4,  32'hFFFF_FFFF, 32'd1,         32'h0,         "alu_sltu"},
    '{4'd10, 32'h0,         32'h1234_5000, 32'h1234_5000, "alu_pass_b"},
    '{4'd15, 32'h5,         32'h7,         32'h0,         "alu_op15"},
    '{4'd0,  32'd7,         32'd8,         32'd15,        "alu_add"},
    '{4'd2,  32'd1,         32'd31,        32'h8000_0000, "alu_sll"},
    '{4'd3,  32'hFFFF_FFFF, 32'd1,         32'd1,         "alu_slt"},
    '{4'd5,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, "alu_xor"},
    '{4'd8,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, "alu_or"},
    '{4'd9,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, "alu_and"},
    '{4'd11, 32'h5,         32'h7,         32'h0,         "alu_op11"},
    '{4'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, "alu_sra_shamt5"}
  };

  // All at pc = 0x40, imm_sb = 0x10: taken -> 0x50, not taken -> 0x44.
  br_vec_t br_tab[9] = '{
    '{1'b1, 3'b000, 32'd5,         32'd5, 1'b1, 32'h50, "br_eq_taken"},
    '{1'b1, 3'b000, 32'd5,         32'd6, 1'b0, 32'h44, "br_eq_not"},
    '{1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h50, "br_lt_signed"},
    '{1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h44, "br_ltu"},
    '{1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h44, "br_ge_signed"},
    '{1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h50, "br_geu"},
    '{1'b1, 3'b001, 32'd5,         32'd6, 1'b1, 32'h50, "br_ne"},
    '{1'b1, 3'b010, 32'd5,         32'd5, 1'b0, 32'h44, "br_f3_010"},
    '{1'b0, 3'b000, 32'd5,         32'd5, 1'b0, 32'h44, "br_disabled"}
  };

  initial begin
    reset            = 1'b1;
    dp_if.pc_en      = 1'b0;
    dp_if.pc_sel     = 2'd0;
    dp_if.alu_op     = 4'd0;
    dp_if.op_a       = 32'h0;
    dp_if.op_b       = 32'h0;
    dp_if.imm_i      = 32'h0;
    dp_if.imm_sb     = 32'h0;
    dp_if.imm_uj     = 32'h0;
    dp_if.branch_en  = 1'b0;
    dp_if.funct3     = 3'd0;

    // Sequential fetch from reset
    cyc();
    reset = 1'b0;
    dp_if.pc_en  = 1'b1;
    dp_if.pc_sel = 2'd0;
    expect_val(K_PC,    "reset_pc",    32'h0);
    expect_val(K_PLUS4, "reset_plus4", 32'h4);
    expect_val(K_IMEM,  "reset_imem",  32'h0);
    expect_val(K_NEXT,  "seq_next0",   32'h4);
    for (int i = 1; i < 3; i++) begin
      cyc();
      expect_val(K_PC,   "seq_pc",   32'(4 * i));
      expect_val(K_IMEM, "seq_imem", 32'(i));
    end
    cyc();
    expect_val(K_PC,   "seq_pc3",   32'd12);
    expect_val(K_IMEM, "seq_imem3", 32'd3);
    dp_if.pc_sel = 2'd3;
    dp_if.op_a   = 32'h100;
    dp_if.imm_i  = 32'h0;
    expect_val(K_NEXT, "jalr_to_100", 32'h100);

    // JAL backwards, then JALR with bit 0 cleared
    cyc();
    expect_val(K_PC, "pc_100", 32'h100);
    dp_if.pc_sel = 2'd1;
    dp_if.imm_uj = 32'hFFFF_FFF8;
    expect_val(K_NEXT, "jal_next", 32'h0F8);
    cyc();
    expect_val(K_PC,    "jal_pc",    32'h0F8);
    expect_val(K_PLUS4, "jal_plus4", 32'h0FC);
    dp_if.pc_sel = 2'd3;
    dp_if.op_a   = 32'h201;
    dp_if.imm_i  = 32'h4;
    expect_val(K_NEXT, "jalr_next", 32'h204);
    cyc();
    expect_val(K_PC, "jalr_pc", 32'h204);
    dp_if.op_a  = 32'h40;
    dp_if.imm_i = 32'h0;
    cyc();
    expect_val(K_PC, "pc_40", 32'h40);

    // Branch conditions with the PC held at 0x40
    dp_if.pc_en  = 1'b0;
    dp_if.pc_sel = 2'd2;
    dp_if.imm_sb = 32'h10;
    foreach (br_tab[i]) begin
      dp_if.branch_en = br_tab[i].en;
      dp_if.funct3    = br_tab[i].f3;
      dp_if.op_a      = br_tab[i].a;
      dp_if.op_b      = br_tab[i].b;
      expect_val(K_TAKEN, br_tab[i].name, {31'd0, br_tab[i].taken});
      expect_val(K_NEXT,  br_tab[i].name, br_tab[i].next);
      cyc();
      expect_val(K_PC, "hold_pc", 32'h40);
    end

    dp_if.branch_en = 1'b0;
    foreach (alu_tab[i]) begin
      dp_if.alu_op = alu_tab[i].op;
      dp_if.op_a   = alu_tab[i].a;
      dp_if.op_b   = alu_tab[i].b;
      expect_val(K_ALU, alu_tab[i].name, alu_tab[i].res);
      cyc();
    end

    // Reset beats an enabled JAL
    dp_if.pc_en  = 1'b1;
    dp_if.pc_sel = 2'd1;
    dp_if.imm_uj = 32'h1000;
    reset        = 1'b1;
    expect_val(K_NEXT, "pending_jal", 32'h1040);
    cyc();
    reset = 1'b0;
    expect_val(K_PC,    "midreset_pc",    32'h0);
    expect_val(K_PLUS4, "midreset_plus4", 32'h4);
    expect_val(K_IMEM,  "midreset_imem",  32'h0);

    // Wrap at the top of the address space
    dp_if.pc_sel = 2'd3;
    dp_if.op_a   = 32'hFFFF_FFFC;
    dp_if.imm_i  = 32'h0;
    cyc();
    expect_val(K_PC,    "top_pc",    32'hFFFF_FFFC);
    expect_val(K_PLUS4, "top_plus4", 32'h0);
    expect_val(K_IMEM,  "top_imem",  32'hFFF);
    dp_if.pc_sel = 2'd0;
    expect_val(K_NEXT, "wrap_next", 32'h0);
    cyc();
    expect_val(K_PC, "wrap_pc", 32'h0);
    dp_if.pc_en = 1'b0;

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
